// File: rtl/eeprom_pkg.sv
// Shared definitions for the serial EEPROM bus master: device id, FSM states,
// bit-phase indices and frame lengths.
package eeprom_pkg;

    localparam logic [3:0] DEV_ID = 4'b1010;

    // Bit phase indices: SCL low / rising / high (sample at end) / falling
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    // Frame lengths in phases, START to end of STOP
    localparam int WR_PHASES = 116;
    localparam int RD_PHASES = 156;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_ACK,
        S_RESTART,
        S_RECV,
        S_MNACK,
        S_STOP,
        S_DONE
    } state_t;

    // Control byte: device id, block select, R/W (1 = read)
    function automatic logic [7:0] ctrl_byte(input logic [2:0] blk, input logic rw);
        return {DEV_ID, blk, rw};
    endfunction

    // Nominal frame length for a successful access
    function automatic int frame_phases(input logic rd);
        return rd ? RD_PHASES : WR_PHASES;
    endfunction

endpackage

// File: rtl/eeprom_wr_i2c_bit_timer.sv
// SCL bit timer: CLK_DIV prescaler feeding a 2-bit phase counter. Held at
// phase 0 while cleared so every frame starts on a bit boundary.
module i2c_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    // Prescaler and phase counter; phase advances on the last clock of a phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= '0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= '0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/eeprom_wr.sv
// Serial EEPROM bus master: turns single-cycle byte-write / random-read
// requests into complete START..STOP frames on scl/sda (sda open-drain).
module eeprom_wr
    import eeprom_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [10:0] addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        nack_err,
    output logic        scl,
    inout  wire         sda
);

    state_t      state;
    state_t      state_nx;
    logic        tick;
    logic [1:0]  phase;
    logic        bit_end;
    logic        sample;
    logic        accept;
    logic        scl_nx;
    logic        oe_nx;
    logic        sda_oe;
    logic        is_rd;
    logic        nack;
    logic [2:0]  bitcnt;
    logic [1:0]  byte_idx;
    logic [7:0]  shreg;
    logic [10:0] addr_q;
    logic [7:0]  data_q;

    i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == S_IDLE),
        .tick  (tick),
        .phase (phase)
    );

    assign bit_end = tick && (phase == P3);
    assign sample  = tick && (phase == P2);
    // The done cycle is already IDLE; keep refusing requests until busy drops
    assign accept  = (state == S_IDLE) && (wr_req || rd_req) && !done;
    assign busy    = (state != S_IDLE) || done;

    // Open-drain: only ever pull low or release
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; every bit-level state moves on at the end of phase 3
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (accept) state_nx = S_START;
            S_START,
            S_RESTART: if (bit_end) state_nx = S_SEND;
            S_SEND:    if (bit_end && bitcnt == 3'd7) state_nx = S_ACK;
            S_ACK: begin
                if (bit_end) begin
                    if (nack) begin
                        state_nx = S_STOP;
                    end else begin
                        case (byte_idx)
                            2'd0:    state_nx = S_SEND;
                            2'd1:    state_nx = is_rd ? S_RESTART : S_SEND;
                            default: state_nx = is_rd ? S_RECV : S_STOP;
                        endcase
                    end
                end
            end
            S_RECV:    if (bit_end && bitcnt == 3'd7) state_nx = S_MNACK;
            S_MNACK:   if (bit_end) state_nx = S_STOP;
            S_STOP:    if (bit_end) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Bus waveform per state and phase (oe = pull sda low)
    always_comb begin
        scl_nx = 1'b1;
        oe_nx  = 1'b0;
        case (state)
            S_START,
            S_RESTART: begin
                scl_nx = (phase != P3);
                oe_nx  = (phase != P0);
            end
            S_SEND: begin
                scl_nx = (phase == P1) || (phase == P2);
                oe_nx  = ~shreg[7];
            end
            S_ACK,
            S_RECV,
            S_MNACK: scl_nx = (phase == P1) || (phase == P2);
            S_STOP: begin
                scl_nx = (phase != P0);
                oe_nx  = (phase == P0) || (phase == P1);
            end
            default: ;
        endcase
    end

    // Registered bus pins: glitch-free, and reset forces the idle bus at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl    <= 1'b1;
            sda_oe <= 1'b0;
        end else begin
            scl    <= scl_nx;
            sda_oe <= oe_nx;
        end
    end

    // Frame control: direction, ACK error, bit and byte sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rd    <= 1'b0;
            nack     <= 1'b0;
            bitcnt   <= '0;
            byte_idx <= '0;
        end else if (accept) begin
            is_rd    <= ~wr_req;  // simultaneous requests: write wins
            nack     <= 1'b0;
            bitcnt   <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                S_SEND,
                S_RECV: if (bit_end) bitcnt <= bitcnt + 3'd1;
                S_ACK: begin
                    if (sample && sda) nack <= 1'b1;
                    if (bit_end) byte_idx <= byte_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Request latch and byte shifter (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= addr;
            data_q <= wr_data;
            shreg  <= ctrl_byte(addr[10:8], 1'b0);
        end else begin
            case (state)
                S_SEND: if (bit_end) shreg <= {shreg[6:0], 1'b0};
                S_ACK: begin
                    // Preload the byte that follows this ACK; the read ctrl
                    // byte waits in the shifter across the repeated START
                    if (bit_end) begin
                        case (byte_idx)
                            2'd0:    shreg <= addr_q[7:0];
                            2'd1:    shreg <= is_rd ? ctrl_byte(addr_q[10:8], 1'b1) : data_q;
                            default: ;
                        endcase
                    end
                end
                S_RECV: if (sample) shreg <= {shreg[6:0], sda};
                default: ;
            endcase
        end
    end

    // Completion reporting, registered out of the DONE state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            nack_err <= 1'b0;
            rd_data  <= '0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                nack_err <= nack;
                if (is_rd && !nack) rd_data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_eeprom_wr.sv
// Directed bench for eeprom_wr with a behavioural 2 KB serial EEPROM slave
// and a bus monitor on scl/sda.
module tb_eeprom_wr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [10:0] addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        nack_err;
    logic        scl;
    wire         sda;

    int tests = 0;
    int fails = 0;

    eeprom_wr #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .nack_err (nack_err),
        .scl      (scl),
        .sda      (sda)
    );

    always #5 clk = ~clk;

    // ---------------- EEPROM slave model ----------------
    logic [7:0] mem [0:2047];
    logic       slave_en = 1'b1;
    logic       s_oe = 1'b0;
    logic       s_active = 1'b0;
    logic       s_tx = 1'b0;
    logic       s_rw = 1'b0;
    logic       s_mack = 1'b0;
    logic [2:0] s_blk = '0;
    logic [7:0] s_ptr = '0;
    logic [7:0] s_sh = '0;
    logic [7:0] s_tx_byte = '0;
    int         s_cnt = 0;
    int         s_idx = 0;
    logic [7:0] log_q [$];
    int         n_start = 0;
    int         n_stop = 0;
    int         mon_err = 0;

    pullup (sda);
    assign sda = s_oe ? 1'b0 : 1'bz;

    // START / repeated START
    initial forever begin
        @(negedge sda);
        if (scl === 1'b1) begin
            n_start++;
            s_active = 1'b1;
            s_cnt = 0;
            s_idx = 0;
            s_tx = 1'b0;
            s_oe = 1'b0;
        end
    end

    // STOP
    initial forever begin
        @(posedge sda);
        if (scl === 1'b1) begin
            n_stop++;
            s_active = 1'b0;
            s_tx = 1'b0;
            s_oe = 1'b0;
        end
    end

    // Sample on SCL rise
    initial forever begin
        @(posedge scl);
        if (s_active) begin
            s_cnt++;
            if (s_cnt <= 8 && !s_tx) s_sh = {s_sh[6:0], sda};
            if (s_cnt == 9 && s_tx) s_mack = sda;
        end
    end

    // Drive on SCL fall
    initial forever begin
        @(negedge scl);
        if (s_active) begin
            if (s_tx) begin
                if (s_cnt >= 1 && s_cnt <= 7) s_oe = ~s_tx_byte[7 - s_cnt];
                else if (s_cnt == 8) s_oe = 1'b0;
                else if (s_cnt == 9) begin
                    s_oe = 1'b0;
                    s_cnt = 0;
                    s_tx = 1'b0;
                end
            end else if (s_cnt == 8) begin
                log_q.push_back(s_sh);
                if (s_idx == 0) begin
                    s_blk = s_sh[3:1];
                    s_rw = s_sh[0];
                end else if (s_idx == 1) begin
                    s_ptr = s_sh;
                end else if (s_idx == 2) begin
                    mem[{s_blk, s_ptr}] = s_sh;
                end
                s_oe = slave_en && (s_idx != 0 || s_sh[7:4] == 4'b1010);
                s_idx++;
            end else if (s_cnt == 9) begin
                s_oe = 1'b0;
                s_cnt = 0;
                if (s_idx == 1 && s_rw && slave_en) begin
                    s_tx = 1'b1;
                    s_tx_byte = mem[{s_blk, s_ptr}];
                    s_oe = ~s_tx_byte[7];
                end
            end
        end
    end

    // While the slave pulls low the line must read 0 (master never drives 1)
    initial forever begin
        @(negedge clk);
        if (s_oe && sda !== 1'b0) mon_err++;
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic issue(input logic w, input logic r, input logic [10:0] a, input logic [7:0] d);
        addr = a;
        wr_data = d;
        wr_req = w;
        rd_req = r;
        @(posedge clk); #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic clear_bus_log();
        log_q.delete();
        n_start = 0;
        n_stop = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++; if (scl !== 1'b1) begin fails++; $display("FAIL reset_scl: got %b expected 1", scl); end
        tests++; if (sda !== 1'b1) begin fails++; $display("FAIL reset_sda: got %b expected 1", sda); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (nack_err !== 1'b0) begin fails++; $display("FAIL reset_nack: got %b expected 0", nack_err); end
        tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int n;
        logic [7:0] exp_b [3];
        exp_b = '{8'hAA, 8'hA3, 8'hC7};
        clear_bus_log();
        issue(1'b1, 1'b0, 11'h5A3, 8'hC7);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_rise: got %b expected 1", busy); end
        wait_done(n);
        tests++; if (n != 465) begin fails++; $display("FAIL wr_latency: got %0d expected 465", n); end
        tests++; if (nack_err !== 1'b0) begin fails++; $display("FAIL wr_nack: got %b expected 0", nack_err); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_done: got %b expected 1", busy); end
        tests++; if (log_q.size() != 3) begin fails++; $display("FAIL wr_nbytes: got %0d expected 3", log_q.size()); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= log_q.size() || log_q[i] !== exp_b[i]) begin
                fails++; $display("FAIL wr_byte%0d: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 8'hxx, exp_b[i]);
            end
        end
        tests++; if (mem[11'h5A3] !== 8'hC7) begin fails++; $display("FAIL wr_mem: got %h expected c7", mem[11'h5A3]); end
        tests++; if (n_start != 1 || n_stop != 1) begin fails++; $display("FAIL wr_start_stop: got %0d/%0d expected 1/1", n_start, n_stop); end
        @(posedge clk); #1;
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL wr_after_done: got done=%b busy=%b expected 0/0", done, busy); end
    endtask

    task automatic test_read();
        int n;
        logic [7:0] exp_b [3];
        exp_b = '{8'hAA, 8'hA3, 8'hAB};
        clear_bus_log();
        s_mack = 1'b0;
        issue(1'b0, 1'b1, 11'h5A3, 8'h00);
        wait_done(n);
        tests++; if (n != 625) begin fails++; $display("FAIL rd_latency: got %0d expected 625", n); end
        tests++; if (rd_data !== 8'hC7) begin fails++; $display("FAIL rd_data: got %h expected c7", rd_data); end
        tests++; if (nack_err !== 1'b0) begin fails++; $display("FAIL rd_nack: got %b expected 0", nack_err); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= log_q.size() || log_q[i] !== exp_b[i]) begin
                fails++; $display("FAIL rd_byte%0d: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 8'hxx, exp_b[i]);
            end
        end
        tests++; if (s_mack !== 1'b1) begin fails++; $display("FAIL rd_master_nack: got %b expected 1", s_mack); end
        tests++; if (n_start != 2 || n_stop != 1) begin fails++; $display("FAIL rd_start_stop: got %0d/%0d expected 2/1", n_start, n_stop); end
        @(posedge clk); #1;
        tests++; if (rd_data !== 8'hC7) begin fails++; $display("FAIL rd_data_hold: got %h expected c7", rd_data); end
    endtask

    task automatic test_no_slave();
        int n;
        clear_bus_log();
        slave_en = 1'b0;
        issue(1'b1, 1'b0, 11'h123, 8'h99);
        wait_done(n);
        // START + ctrl byte + ACK slot is 40 phases, then STOP: 44 phases
        tests++; if (n != 177) begin fails++; $display("FAIL ns_latency: got %0d expected 177", n); end
        tests++; if (nack_err !== 1'b1) begin fails++; $display("FAIL ns_nack: got %b expected 1", nack_err); end
        tests++; if (rd_data !== 8'hC7) begin fails++; $display("FAIL ns_rd_data: got %h expected c7", rd_data); end
        tests++; if (log_q.size() != 1) begin fails++; $display("FAIL ns_nbytes: got %0d expected 1", log_q.size()); end
        tests++; if (n_start != 1 || n_stop != 1) begin fails++; $display("FAIL ns_start_stop: got %0d/%0d expected 1/1", n_start, n_stop); end
        tests++; if (mem[11'h123] !== 8'hFF) begin fails++; $display("FAIL ns_mem: got %h expected ff", mem[11'h123]); end
        slave_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int first = -1;
        logic [7:0] exp_b [3];
        exp_b = '{8'hA0, 8'hF0, 8'h5A};
        clear_bus_log();
        issue(1'b1, 1'b1, 11'h0F0, 8'h5A);
        addr = 11'h7FF;
        wr_data = 8'h00;
        for (int n = 1; n <= 700; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = n;
            end
            rd_req = (n == 100);
        end
        tests++; if (ndone != 1) begin fails++; $display("FAIL b2b_done_count: got %0d expected 1", ndone); end
        tests++; if (first != 465) begin fails++; $display("FAIL b2b_latency: got %0d expected 465", first); end
        tests++; if (n_start != 1 || n_stop != 1) begin fails++; $display("FAIL b2b_start_stop: got %0d/%0d expected 1/1", n_start, n_stop); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= log_q.size() || log_q[i] !== exp_b[i]) begin
                fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 8'hxx, exp_b[i]);
            end
        end
        tests++; if (mem[11'h0F0] !== 8'h5A) begin fails++; $display("FAIL b2b_mem: got %h expected 5a", mem[11'h0F0]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] exp_b [3];
        exp_b = '{8'hA0, 8'h00, 8'h3C};
        issue(1'b0, 1'b1, 11'h2C4, 8'h00);
        // Phase 55 of the frame lies inside the address byte (phases 40..75)
        repeat (219) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (scl !== 1'b1) begin fails++; $display("FAIL rst_mid_scl: got %b expected 1", scl); end
        tests++; if (sda !== 1'b1 || dut.sda_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_sda: got %b expected 1", sda); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL rst_mid_rd_data: got %h expected 00", rd_data); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_bus_log();
        issue(1'b1, 1'b0, 11'h000, 8'h3C);
        wait_done(n);
        tests++; if (n != 465) begin fails++; $display("FAIL rst_wr_latency: got %0d expected 465", n); end
        tests++; if (nack_err !== 1'b0) begin fails++; $display("FAIL rst_wr_nack: got %b expected 0", nack_err); end
        tests++; if (mem[11'h000] !== 8'h3C) begin fails++; $display("FAIL rst_wr_mem: got %h expected 3c", mem[11'h000]); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= log_q.size() || log_q[i] !== exp_b[i]) begin
                fails++; $display("FAIL rst_wr_byte%0d: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 8'hxx, exp_b[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_monitor();
        tests++; if (mon_err != 0) begin fails++; $display("FAIL sda_contention: got %0d events expected 0", mon_err); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'hFF;
        test_reset();
        test_write();
        test_read();
        test_no_slave();
        test_back_to_back();
        test_reset_mid();
        test_monitor();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
